dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the far side of the processor datapath's load/store interface. It accepts the address (OPResult), store data (WriteData) and the write strobe, and returns ReadData in the same cycle. It holds a word-addressed RAM plus a small memory-mapped register block: cycle counter, output port, store counter, and a sticky fault/status pair. Writes commit on the clock edge; reads are combinational, as the single-cycle datapath requires.

## Interface
- ADDR_BITS, 6, log2 of RAM depth in words; DEPTH = 2**ADDR_BITS.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store strobe for the current cycle.
- MemRead  input  1  load strobe for the current cycle (driven from MemtoReg).
- Addr  input  32  byte address (datapath OPResult).
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational.
- IOOut  output  32  output-port register.
- Fault  output  1  sticky access-fault flag.

## Operation
- Access: cycle with MemRead or MemWrite high. With both high, perform the write; ReadData is still driven.
- Region decode: Addr[31:8] == 24'hFFFFFF selects MMIO. Otherwise RAM, legal only when Addr < DEPTH*4.
- RAM index: Addr[ADDR_BITS+1:2].
- MMIO registers:
  - 0xFFFFFF00 CYCLES: 32-bit, increments every cycle and wraps at 2^32. Any write loads 0.
  - 0xFFFFFF04 IOOUT: read/write; drives IOOut.
  - 0xFFFFFF08 STATUS: bit0 = Fault, other bits read 0. Writing data bit0 = 1 clears Fault; bit0 = 0 has no effect.
  - 0xFFFFFF0C STORES: 16-bit count in [15:0], upper bits read 0. Counts committed RAM writes and saturates at 0xFFFF. Read-only; writes are ignored and do not fault.
  - 0xFFFFFF10 FAULTADDR: read-only. Captures Addr of the first fault while Fault is 0.
- Fault conditions on an access:
  - Addr[1:0] != 0;
  - RAM address >= DEPTH*4;
  - MMIO offset not listed above.
- On a faulting access:
  - the write is suppressed;
  - ReadData = 0;
  - Fault is set at the edge;
  - FAULTADDR is loaded only if Fault was 0 before the edge.
- Non-faulting read: ReadData = addressed word.
- No access (both strobes low): ReadData still shows the decoded word for any legal address, 0 otherwise. No state changes except CYCLES.
- Reset: RAM contents are not reset.

## Timing
- Reset values: ReadData follows decode; IOOut = 0; Fault = 0; CYCLES = 0; STORES = 0; FAULTADDR = 0.
- Reset asserted mid-operation clears all registers immediately, without waiting for a clock edge. A write in the same cycle as reset is lost.
- Write latency: committed at the rising edge ending the access cycle.
  - A read of the same address in the same cycle returns the old value.
  - A read in the next cycle returns the new value.
- CYCLES: after the edge with a CYCLES write, the value is 0. On the next edge it is 1.
- STATUS clear and a new fault cannot coincide, since there is one access per cycle. A write to STATUS is itself legal.
- Read path is combinational: Addr to ReadData with no registers.

## Test plan
- Reset, store 0xDEADBEEF to 0x0000_0010, load 0x10 next cycle:
  - same-cycle load returns the prior value;
  - next-cycle load returns 0xDEADBEEF;
  - STORES = 1.
- Store 0x12345678 to 0xFFFFFF04 -> IOOut = 0x12345678 after the edge; load 0xFFFFFF04 returns the same value.
- Count cycles:
  - after reset release, load CYCLES at cycle 5 -> 5;
  - write CYCLES -> reads 0 the next cycle, 1 the cycle after.
- Misaligned store to 0x0000_0002, then out-of-range load at 0x0000_0100 (ADDR_BITS = 6):
  - the store does not change RAM word 0;
  - Fault = 1;
  - FAULTADDR = 0x00000002, not overwritten by the second fault;
  - ReadData = 0 on the faulting load.
- Write 0x1 to STATUS -> Fault = 0. A subsequent fault at 0xFFFFFF20 sets FAULTADDR = 0xFFFFFF20.
- Fill STORES to 0xFFFF via 65535 stores, store once more -> STORES stays 0xFFFF. Assert reset mid-stream -> IOOut, Fault and STORES are 0 immediately.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle datapath: word RAM plus a small MMIO block
// (cycle counter, output port, store counter, sticky fault status and fault address).
module dmem_responder #(
   parameter int ADDR_BITS = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [31:0] IOOut,
   output logic        Fault
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [31:0] mem [DEPTH];

   logic [31:0] cyclesQ, cyclesD;
   logic [31:0] ioOutQ, ioOutD;
   logic        faultQ, faultD;
   logic [15:0] storesQ, storesD;
   logic [31:0] faultAddrQ, faultAddrD;

   logic                 isMmio;
   logic                 aligned;
   logic                 ramInRange;
   logic                 mmioHit;
   logic                 legal;
   logic                 accessFault;
   logic                 wrOk;
   logic                 ramWe;
   logic [ADDR_BITS-1:0] ramIdx;
   logic [31:0]          rdWord;

   // Address decode: anything not aligned, out of RAM range, or an unlisted MMIO offset is illegal.
   always_comb begin
      isMmio     = (Addr[31:8] == 24'hFFFFFF);
      aligned    = (Addr[1:0] == 2'b00);
      ramInRange = (Addr[31:ADDR_BITS+2] == '0);
      ramIdx     = Addr[ADDR_BITS+1:2];
      mmioHit    = 1'b0;
      case (Addr[7:0])
         8'h00, 8'h04, 8'h08, 8'h0C, 8'h10: mmioHit = 1'b1;
         default:                           mmioHit = 1'b0;
      endcase
      legal       = aligned && (isMmio ? mmioHit : ramInRange);
      accessFault = (MemRead || MemWrite) && !legal;
      wrOk        = MemWrite && legal;
      ramWe       = wrOk && !isMmio && !reset;
   end

   // Combinational read mux; illegal addresses always return zero.
   always_comb begin
      rdWord = '0;
      if (isMmio) begin
         case (Addr[7:0])
            8'h00:   rdWord = cyclesQ;
            8'h04:   rdWord = ioOutQ;
            8'h08:   rdWord = {31'd0, faultQ};
            8'h0C:   rdWord = {16'd0, storesQ};
            8'h10:   rdWord = faultAddrQ;
            default: rdWord = '0;
         endcase
      end else begin
         rdWord = mem[ramIdx];
      end
      ReadData = legal ? rdWord : '0;
   end

   // Register-block next state; the fault address is only captured while no fault is pending.
   always_comb begin
      cyclesD    = cyclesQ + 32'd1;
      ioOutD     = ioOutQ;
      faultD     = faultQ;
      storesD    = storesQ;
      faultAddrD = faultAddrQ;
      if (wrOk && isMmio) begin
         case (Addr[7:0])
            8'h00:   cyclesD = '0;
            8'h04:   ioOutD  = WriteData;
            8'h08:   if (WriteData[0]) faultD = 1'b0;
            default: ;
         endcase
      end
      if (ramWe && (storesQ != 16'hFFFF)) storesD = storesQ + 16'd1;
      if (accessFault) begin
         faultD = 1'b1;
         if (!faultQ) faultAddrD = Addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyclesQ    <= '0;
         ioOutQ     <= '0;
         faultQ     <= 1'b0;
         storesQ    <= '0;
         faultAddrQ <= '0;
      end else begin
         cyclesQ    <= cyclesD;
         ioOutQ     <= ioOutD;
         faultQ     <= faultD;
         storesQ    <= storesD;
         faultAddrQ <= faultAddrD;
      end
   end

   // RAM contents survive reset; only the write enable is suppressed while reset is high.
   always_ff @(posedge clk) begin
      if (ramWe) mem[ramIdx] <= WriteData;
   end

   assign IOOut = ioOutQ;
   assign Fault = faultQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: a vector table for single-cycle accesses and
// hand-written sequences for the cycle counter, store saturation and asynchronous reset.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [31:0] IOOut;
   logic        Fault;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] A_CYC  = 32'hFFFFFF00;
   localparam logic [31:0] A_IO   = 32'hFFFFFF04;
   localparam logic [31:0] A_STAT = 32'hFFFFFF08;
   localparam logic [31:0] A_STOR = 32'hFFFFFF0C;
   localparam logic [31:0] A_FADR = 32'hFFFFFF10;

   typedef struct {
      string       name;
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chkRd;
      logic [31:0] expRd;
      logic [31:0] expIo;
      logic        expFault;
   } vec_t;

   vec_t vecs[$];

   dmem_responder #(.ADDR_BITS(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .IOOut     (IOOut),
      .Fault     (Fault)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a,
                                input logic [31:0] wd);
      MemWrite  = we;
      MemRead   = re;
      Addr      = a;
      WriteData = wd;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void addVec(input string n, input logic we, input logic re,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic chk, input logic [31:0] rd,
                                  input logic [31:0] io, input logic f);
      vec_t v;
      v.name = n; v.we = we; v.re = re; v.addr = a; v.wdata = wd;
      v.chkRd = chk; v.expRd = rd; v.expIo = io; v.expFault = f;
      vecs.push_back(v);
   endfunction

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, A_CYC, 32'd0);

      // ReadData is checked before the edge ending the cycle; IOOut/Fault after it.
      addVec("st_init",     1, 0, 32'h10,       32'h11111111, 0, 32'h0,        32'h0,        0);
      addVec("st_ld_same",  1, 1, 32'h10,       32'hDEADBEEF, 1, 32'h11111111, 32'h0,        0);
      addVec("ld_next",     0, 1, 32'h10,       32'h0,        1, 32'hDEADBEEF, 32'h0,        0);
      addVec("stores_2",    0, 1, A_STOR,       32'h0,        1, 32'd2,        32'h0,        0);
      addVec("io_write",    1, 0, A_IO,         32'h12345678, 1, 32'h0,        32'h12345678, 0);
      addVec("io_read",     0, 1, A_IO,         32'h0,        1, 32'h12345678, 32'h12345678, 0);
      addVec("st_word0",    1, 0, 32'h0,        32'hAAAA5555, 0, 32'h0,        32'h12345678, 0);
      addVec("misalign_st", 1, 0, 32'h2,        32'hFFFFFFFF, 1, 32'h0,        32'h12345678, 1);
      addVec("word0_kept",  0, 1, 32'h0,        32'h0,        1, 32'hAAAA5555, 32'h12345678, 1);
      addVec("oor_load",    0, 1, 32'h100,      32'h0,        1, 32'h0,        32'h12345678, 1);
      addVec("faultaddr_1", 0, 1, A_FADR,       32'h0,        1, 32'h2,        32'h12345678, 1);
      addVec("status_1",    0, 1, A_STAT,       32'h0,        1, 32'h1,        32'h12345678, 1);
      addVec("stores_3",    0, 1, A_STOR,       32'h0,        1, 32'd3,        32'h12345678, 1);
      addVec("stat_wr0",    1, 0, A_STAT,       32'h0,        1, 32'h1,        32'h12345678, 1);
      addVec("stat_clear",  1, 0, A_STAT,       32'h1,        1, 32'h1,        32'h12345678, 0);
      addVec("status_0",    0, 1, A_STAT,       32'h0,        1, 32'h0,        32'h12345678, 0);
      addVec("bad_mmio",    0, 1, 32'hFFFFFF20, 32'h0,        1, 32'h0,        32'h12345678, 1);
      addVec("faultaddr_2", 0, 1, A_FADR,       32'h0,        1, 32'hFFFFFF20, 32'h12345678, 1);
      addVec("stores_wr",   1, 0, A_STOR,       32'h1234,     1, 32'd3,        32'h12345678, 1);
      addVec("stores_ro",   0, 1, A_STOR,       32'h0,        1, 32'd3,        32'h12345678, 1);
      addVec("stat_clr2",   1, 0, A_STAT,       32'h1,        1, 32'h1,        32'h12345678, 0);
      addVec("fadr_wr_ok",  1, 0, A_FADR,       32'h5,        1, 32'hFFFFFF20, 32'h12345678, 0);
      addVec("idle_oor",    0, 0, 32'h104,      32'h0,        1, 32'h0,        32'h12345678, 0);
      addVec("idle_ram",    0, 0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 32'h12345678, 0);

      // Reset state while reset is still held.
      #1;
      checkOutput("rst_cycles", ReadData, 32'h0);
      checkOutput("rst_ioout", IOOut, 32'h0);
      checkOutput("rst_fault", {31'd0, Fault}, 32'h0);
      Addr = A_STOR; #1;
      checkOutput("rst_stores", ReadData, 32'h0);
      Addr = A_FADR; #1;
      checkOutput("rst_faultaddr", ReadData, 32'h0);
      Addr = A_CYC;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("cycles_0", ReadData, 32'd0);
      repeat (5) tick();
      checkOutput("cycles_5", ReadData, 32'd5);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
         #1;
         if (vecs[i].chkRd) checkOutput({vecs[i].name, "_rd"}, ReadData, vecs[i].expRd);
         tick();
         checkOutput({vecs[i].name, "_io"}, IOOut, vecs[i].expIo);
         checkOutput({vecs[i].name, "_fault"}, {31'd0, Fault}, {31'd0, vecs[i].expFault});
      end

      // Writing CYCLES zeroes it at the edge; it counts again from the next edge.
      applyStimulus(1'b1, 1'b0, A_CYC, 32'hFFFFFFFF);
      tick();
      applyStimulus(1'b0, 1'b1, A_CYC, 32'h0);
      #1;
      checkOutput("cycles_clr0", ReadData, 32'd0);
      tick();
      checkOutput("cycles_clr1", ReadData, 32'd1);

      // Three RAM stores so far; drive the count to 0xFFFE, then across saturation.
      for (int n = 0; n < 65531; n++) begin
         applyStimulus(1'b1, 1'b0, 32'h20, n);
         tick();
      end
      applyStimulus(1'b0, 1'b1, A_STOR, 32'h0);
      #1;
      checkOutput("stores_fffe", ReadData, 32'h0000FFFE);
      applyStimulus(1'b0, 1'b1, 32'h20, 32'h0);
      #1;
      checkOutput("bulk_last", ReadData, 32'd65530);
      applyStimulus(1'b1, 1'b0, 32'h24, 32'h0BADF00D);
      tick();
      applyStimulus(1'b0, 1'b1, A_STOR, 32'h0);
      #1;
      checkOutput("stores_ffff", ReadData, 32'h0000FFFF);
      applyStimulus(1'b1, 1'b0, 32'h28, 32'h55AA55AA);
      tick();
      applyStimulus(1'b0, 1'b1, A_STOR, 32'h0);
      #1;
      checkOutput("stores_sat", ReadData, 32'h0000FFFF);

      // Pend a fault, then assert reset mid-cycle during a store.
      applyStimulus(1'b0, 1'b1, 32'h3, 32'h0);
      tick();
      checkOutput("pre_rst_fault", {31'd0, Fault}, 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h24, 32'hCAFEF00D);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midrst_ioout", IOOut, 32'h0);
      checkOutput("midrst_fault", {31'd0, Fault}, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b1, A_STOR, 32'h0);
      #1;
      checkOutput("midrst_stores", ReadData, 32'h0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'h24, 32'h0);
      #1;
      checkOutput("rst_write_lost", ReadData, 32'h0BADF00D);
      applyStimulus(1'b0, 1'b1, 32'h28, 32'h0);
      #1;
      checkOutput("sat_store_ram", ReadData, 32'h55AA55AA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
